// File: rtl/demux_rr_pkg.sv
// Shared types and helpers for the round-robin demux dispatcher.
`timescale 1ns/1ps
package demux_rr_pkg;

  localparam logic [2:0] SEL_NONE = 3'd7;

  typedef enum logic [1:0] {
    EMPTY,
    PEND,
    SEND
  } dispatch_state_t;

  // First set bit of mask scanning upward from ptr, wrapping at nports.
  // Returns ptr when mask is empty; callers only use it with a non-zero mask.
  function automatic logic [2:0] rr_pick(input logic [2:0] ptr,
                                         input logic [6:0] mask,
                                         input int unsigned nports);
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    idx   = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < nports; k++) begin
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = (idx == 3'(nports - 1)) ? 3'd0 : idx + 3'd1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/comb_demux_nb_1toN.sv
// Combinational 1-to-N demux: the selected lane carries in_, all others are zero.
`timescale 1ns/1ps
module comb_demux_nb_1toN #(
  parameter int unsigned NBITS  = 4,
  parameter int unsigned NPORTS = 5
) (
  input  logic [2:0]              sel,
  input  logic [NBITS-1:0]        in_,
  output logic [NPORTS*NBITS-1:0] out
);

  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (sel == 3'(i)) out[i*NBITS +: NBITS] = in_;
    end
  end

endmodule

// File: rtl/demux_rr_dispatch.sv
// Round-robin dispatcher: one-entry buffer steering each message to one enabled port.
`timescale 1ns/1ps
module demux_rr_dispatch
  import demux_rr_pkg::*;
#(
  parameter int unsigned NBITS  = 4,
  parameter int unsigned NPORTS = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        en_mask,
  input  logic                     istream_val,
  output logic                     istream_rdy,
  input  logic [NBITS-1:0]         istream_msg,
  output logic [NPORTS-1:0]        ostream_val,
  input  logic [NPORTS-1:0]        ostream_rdy,
  output logic [NPORTS*NBITS-1:0]  ostream_msg,
  output logic [2:0]               sel,
  output logic [7:0]               disp_count
);

  dispatch_state_t  state, state_nxt;
  logic [2:0]       ptr, ptr_nxt;
  logic [2:0]       tgt, tgt_nxt;
  logic [NBITS-1:0] buf_msg;
  logic [6:0]       mask7;
  logic             in_fire;
  logic             out_fire;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    tgt_nxt   = tgt;
    mask7     = '0;
    mask7[NPORTS-1:0] = en_mask;

    out_fire    = (state == SEND) && ostream_rdy[tgt];
    istream_rdy = reset && ((state == EMPTY) || out_fire);
    in_fire     = istream_val && istream_rdy;

    if (out_fire) ptr_nxt = (tgt == 3'(NPORTS - 1)) ? 3'd0 : tgt + 3'd1;

    // A refill in the same cycle as a send picks its target from the advanced pointer.
    case (state)
      EMPTY, SEND: begin
        if (in_fire) begin
          if (|en_mask) begin
            state_nxt = SEND;
            tgt_nxt   = rr_pick(ptr_nxt, mask7, NPORTS);
          end else begin
            state_nxt = PEND;
          end
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      PEND: begin
        if (|en_mask) begin
          state_nxt = SEND;
          tgt_nxt   = rr_pick(ptr, mask7, NPORTS);
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      ptr        <= '0;
      tgt        <= '0;
      buf_msg    <= '0;
      disp_count <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      tgt   <= tgt_nxt;
      if (in_fire)  buf_msg    <= istream_msg;
      if (out_fire) disp_count <= disp_count + 8'd1;
    end
  end

  always_comb begin
    ostream_val = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      ostream_val[i] = (state == SEND) && (tgt == 3'(i));
    end
    sel = (state == SEND) ? tgt : SEL_NONE;
  end

  comb_demux_nb_1toN #(
    .NBITS  (NBITS),
    .NPORTS (NPORTS)
  ) u_demux (
    .sel (sel),
    .in_ (buf_msg),
    .out (ostream_msg)
  );

endmodule
